fp_output_packer: RTL

- Parametrised, pipelined successor to the combinational result-to-IEEE754 output stage.
- Accepts LANES independent FPU results per beat as separate fields: mantissa, exponent, sign, nan, inf, err.
- Packs each lane into S or D IEEE754 format and buffers the packed beats in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Tracks errors per beat and in a sticky flag, and counts delivered beats. Sits between the FPU datapath and the register-file writeback.

---
 rtl/fp_output_packer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fp_output_packer.sv
// rtl/fp_output_packer.sv - packs per-lane FPU results into IEEE754 words and buffers them in a FIFO
module fp_output_packer #(
    parameter int LANES    = 2,
    parameter int REG_SIZE = 64,
    parameter int MAN_W    = 52,
    parameter int EXP_W    = 11,
    parameter int DEPTH    = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_mode,
    input  logic [LANES*MAN_W-1:0]    in_man,
    input  logic [LANES*EXP_W-1:0]    in_exp,
    input  logic [LANES-1:0]          in_sign,
    input  logic [LANES-1:0]          in_nan,
    input  logic [LANES-1:0]          in_inf,
    input  logic [LANES-1:0]          in_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*REG_SIZE-1:0] out_data,
    output logic                      out_err,
    output logic                      sticky_err,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          beat_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = LANES * REG_SIZE;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BW-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0] mem_err;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             ready_q;
    logic             push;
    logic             pop;
    logic [BW-1:0]    packed_beat;
    logic             beat_err;

    // NaN outranks infinity, which outranks the normal field copy.
    function automatic logic [63:0] pack_lane(
        input logic             mode,
        input logic [MAN_W-1:0] m,
        input logic [EXP_W-1:0] e,
        input logic             s,
        input logic             nan,
        input logic             inf
    );
        logic [63:0] w;
        if (mode) begin
            if (nan)
                w = {s, 11'h7FF, 52'h1};
            else if (inf)
                w = {s, 11'h7FF, 52'h0};
            else
                w = {s, e[10:0], m[51:0]};
        end else begin
            if (nan)
                w = {32'b0, s, 8'hFF, 23'h000001};
            else if (inf)
                w = {32'b0, s, 8'hFF, 23'h0};
            else
                w = {32'b0, s, e[7:0], m[22:0]};
        end
        return w;
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign packed_beat[i*REG_SIZE +: REG_SIZE] = REG_SIZE'(pack_lane(
            in_mode,
            in_man[i*MAN_W +: MAN_W],
            in_exp[i*EXP_W +: EXP_W],
            in_sign[i],
            in_nan[i],
            in_inf[i]));
    end

    assign beat_err  = |in_err;
    assign in_ready  = ready_q;
    assign out_valid = (count != '0);
    assign push      = in_valid & ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= packed_beat;
            mem_err[wr_ptr]  <= beat_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ready_q    <= 1'b0;
            sticky_err <= 1'b0;
            beat_cnt   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                beat_cnt <= beat_cnt + 1'b1;
            end
            count   <= count_nxt;
            // Registered so out_ready never reaches in_ready combinationally.
            ready_q <= (count_nxt < FULL_CNT);
            if (push && beat_err)
                sticky_err <= 1'b1;
            else if (err_clr)
                sticky_err <= 1'b0;
        end
    end

    assign out_data = out_valid ? mem_data[rd_ptr] : '0;
    assign out_err  = out_valid & mem_err[rd_ptr];

endmodule
